// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration constants for muldiv_seq.
// Rev 1.0
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  localparam int MD_ITER    = 32;
  localparam int MD_LATENCY = 34;

endpackage

`default_nettype wire

// File: rtl/cla_adder32.sv
// cla_adder32: 32-bit adder, per-bit generate/propagate cells, lookahead inside 4-bit groups.
// Rev 1.0
`default_nettype none

module cla_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_i,
  output logic [31:0] sum,
  output logic        carry_o
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [8:0]  grp_c;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign gen[i]  = a[i] & b[i];
    assign prop[i] = a[i] ^ b[i];
  end

  assign grp_c[0] = carry_i;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;

    assign gg   = gen[4*k +: 4];
    assign pp   = prop[4*k +: 4];
    assign c[0] = grp_c[k];
    assign c[1] = gg[0] | (pp[0] & c[0]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & c[0]);

    // Group carry-out is formed from group G/P so it never waits on c[3].
    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p = &pp;
    assign grp_c[k+1] = grp_g | (grp_p & c[0]);

    assign sum[4*k +: 4] = pp ^ c;
  end

  assign carry_o = grp_c[8];

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// muldiv_seq: 34-cycle iterative MULT/MULTU/DIV/DIVU on one shared cla_adder32.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero port and a 1-cycle divide-by-zero path.
`default_nettype none

module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic        div_zero
`endif
);

  md_state_e   state;
  md_state_e   state_n;
  logic [4:0]  count;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] operand;
  logic        is_div;
  logic        res_sign;
  logic        rem_sign;

  logic        div_op;
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        dz_take;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_sum;
  logic        add_co;
  logic        sub_ok;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;

  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign div_op    = (op == MD_DIV) || (op == MD_DIVU);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = signed_op & src_a[31];
  assign b_neg     = signed_op & src_b[31];
  assign abs_a     = a_neg ? (32'd0 - src_a) : src_a;
  assign abs_b     = b_neg ? (32'd0 - src_b) : src_b;

`ifdef DIV_ZERO_FLAG_EN
  assign dz_take = start && !cancel && div_op && (src_b == 32'd0);
`else
  assign dz_take = 1'b0;
`endif

  cla_adder32 u_adder (
    .a       (add_a),
    .b       (add_b),
    .carry_i (add_ci),
    .sum     (add_sum),
    .carry_o (add_co)
  );

  // Divide: remainder bit shifted out of acc_hi[31] means rem >= 2^32 > divisor,
  // so the subtraction must succeed even though the 32-bit adder loses that bit.
  always_comb begin
    add_a   = acc_hi;
    add_b   = acc_lo[0] ? operand : 32'd0;
    add_ci  = 1'b0;
    sub_ok  = 1'b0;
    calc_hi = {add_co, add_sum[31:1]};
    calc_lo = {add_sum[0], acc_lo[31:1]};
    if (is_div) begin
      add_a   = {acc_hi[30:0], acc_lo[31]};
      add_b   = ~operand;
      add_ci  = 1'b1;
      sub_ok  = add_co | acc_hi[31];
      calc_hi = sub_ok ? add_sum : add_a;
      calc_lo = {acc_lo[30:0], sub_ok};
    end
  end

  always_comb begin
    prod_fix = res_sign ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    fix_hi   = prod_fix[63:32];
    fix_lo   = prod_fix[31:0];
    if (is_div) begin
      fix_lo = res_sign ? (32'd0 - acc_lo) : acc_lo;
      fix_hi = rem_sign ? (32'd0 - acc_hi) : acc_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = (state != MD_IDLE);
    done    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && !cancel) begin
          state_n = dz_take ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        if (cancel) begin
          state_n = MD_IDLE;
        end else if (count == 5'(MD_ITER - 1)) begin
          state_n = MD_FIX;
        end
      end
      MD_FIX: begin
        state_n = cancel ? MD_IDLE : MD_DONE;
      end
      MD_DONE: begin
        done    = 1'b1;
        state_n = MD_IDLE;
      end
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 5'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      operand  <= 32'd0;
      is_div   <= 1'b0;
      res_sign <= 1'b0;
      rem_sign <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !cancel) begin
            count    <= 5'd0;
            is_div   <= div_op;
            res_sign <= a_neg ^ b_neg;
            rem_sign <= a_neg;
            acc_hi   <= 32'd0;
            operand  <= div_op ? abs_b : abs_a;
            acc_lo   <= div_op ? abs_a : abs_b;
            if (dz_take) begin
              hi <= src_a;
              lo <= 32'hFFFF_FFFF;
            end
          end
        end
        MD_CALC: begin
          if (!cancel) begin
            acc_hi <= calc_hi;
            acc_lo <= calc_lo;
            count  <= count + 5'd1;
          end
        end
        MD_FIX: begin
          if (!cancel) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_zero <= 1'b0;
    end else begin
      div_zero <= (state == MD_IDLE) && dz_take;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized + directed scoreboard bench for muldiv_seq.
// Rev 1.0
`default_nettype none

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          issued;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: signed ops use 64-bit signed arithmetic, divide truncates toward zero.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    logic [63:0] p;
    sa     = longint'($signed(a));
    sb_v   = longint'($signed(b));
    e.lat  = 34;
    e.dz   = 1'b0;
    e.issued = 0;
    case (o)
      2'b00: begin p = 64'(sa * sb_v); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          p = 64'(sa / sb_v); e.lo = p[31:0];
          p = 64'(sa % sb_v); e.hi = p[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
`ifdef DIV_ZERO_FLAG_EN
    if (o[1] && b == 32'd0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.lat = 1;
      e.dz  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Monitor: every DONE pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("latency", 64'(cyc - e.issued), 64'(e.lat));
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
`endif
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    exp_t e;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (expect_done) begin
      e = model(o, a, b);
      e.issued = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // BUSY profile over a full MULTU run
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      chk($sformatf("busy_cycle%0d", k), {63'd0, busy}, {63'd0, (k <= 34)});
      @(posedge clk); #1;
    end

    wait_idle();
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();

    // Back-to-back: next START in cycle 35 must be taken
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    repeat (34) @(posedge clk);
    #1;
    chk("b2b_idle_c35", {63'd0, busy}, 64'd0);
    issue(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b1);
    @(negedge clk);
    chk("b2b_accepted", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    wait_idle();

    // START while busy is dropped
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    // Cancel mid-CALC with known prior HI/LO
    issue(2'b11, 32'h0000_2211, 32'h0000_0100, 1'b1);
    wait_idle();
    issue(2'b01, 32'd3, 32'd4, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy_n1", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("cancel_hi", {32'd0, hi}, 64'h11);
    chk("cancel_lo", {32'd0, lo}, 64'h22);

    // START with CANCEL in IDLE is refused
    start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Divide by zero
    issue(2'b11, 32'd5, 32'd0, 1'b1);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 1'b1);
      wait_idle();
    end

    // Asynchronous reset during cycle 20 of an op
    issue(2'b00, 32'hDEAD_BEEF, 32'h0000_0777, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(2'b01, 32'd6, 32'd7, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    chk("pending_results", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage: it accepts MULT, MULTU, DIV and DIVU requests and runs them over 32 iterations on one shared 32-bit carry-lookahead adder. Each run finishes with a one-cycle sign-fix step, after which the HI/LO result registers are written. The pipeline holds the instruction with BUSY and observes completion on DONE; an exception flush aborts an in-flight operation via CANCEL.

## Interface
- No parameters; width fixed at 32.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- OP  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with START.
- SRC_A  in  32  multiplicand or dividend; sampled with START.
- SRC_B  in  32  multiplier or divisor; sampled with START.
- CANCEL  in  1  synchronous abort (pipeline flush).
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- HI  out  32  product[63:32] or remainder.
- LO  out  32  product[31:0] or quotient.
- DIV_ZERO  out  1  present only with DIV_ZERO_FLAG_EN; see Configuration.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - START=1 and CANCEL=0 -> latch operands and go to CALC with iteration count = 0.
  - Signed ops latch |SRC_A| and |SRC_B| and record two sign flags:
    - result sign = sign(A) xor sign(B);
    - remainder sign = sign(A).
  - Unsigned ops latch operands unchanged; sign flags = 0.
- **CALC** (32 cycles, count 0..31; go to FIX when count = 31)
  - Multiply (shift-add): if acc_lo[0]=1, the adder computes acc_hi + multiplicand with carry-in 0; otherwise it adds 0. Then {carry_out, sum, acc_lo} shifts right by 1 into {acc_hi, acc_lo}.
  - Divide (restoring):
    - shift {rem, quot} left by 1;
    - the adder computes rem + ~divisor with carry-in 1;
    - carry_out=1 -> rem = sum and quot[0] = 1; otherwise rem is kept and quot[0] = 0.
  - The adder is the only arithmetic resource used in CALC.
- **FIX** (1 cycle)
  - Multiply: if result sign = 1, the 64-bit product is two's-complement negated.
  - Divide: quotient is negated if result sign = 1; remainder is negated if remainder sign = 1.
  - HI and LO are written at the end of FIX. Go to DONE.
- **DONE** (1 cycle): DONE=1, then go to IDLE.
- **Divide by zero, macro off:** the algorithm runs unmodified.
  - Unsigned core result: quotient 0xFFFFFFFF, remainder = |dividend|; sign fix then applies.
  - Example: DIV -7/0 -> LO=0x00000001, HI=0xFFFFFFF9.
- **CANCEL**
  - In CALC or FIX: next state is IDLE; HI/LO unchanged; no DONE.
  - In DONE: ignored, since the result is already committed.
  - In IDLE together with START: START is not accepted.
- START while BUSY=1 is ignored; no queuing.
- **RST** (any time, including mid-operation): state IDLE, count 0, accumulators 0, HI=0, LO=0, BUSY=0, DONE=0, DIV_ZERO=0.

## Timing
- START accepted in cycle 0:
  - cycles 1–32: CALC;
  - cycle 33: FIX;
  - cycle 34: DONE=1, with HI/LO already showing the new values.
- Latency is 34 cycles for all ops.
- BUSY is high in cycles 1–34.
- The earliest next START is accepted in cycle 35 (state is IDLE, BUSY=0).
- HI/LO are registered; they change only on the clock edge that ends FIX.
- CANCEL asserted in cycle n (1 ≤ n ≤ 33) -> BUSY=0 in cycle n+1.

## Configuration
- Macro: DIV_ZERO_FLAG_EN.
- **Defined:**
  - DIV/DIVU with SRC_B=0 at START goes IDLE -> DONE directly, skipping CALC and FIX.
  - HI=SRC_A and LO=0xFFFFFFFF are written at that edge.
  - DONE=1 and DIV_ZERO=1 in cycle 1; latency is 1.
  - DIV_ZERO is 0 in every other cycle.
- **Undefined:** the DIV_ZERO port and its logic are absent; divide-by-zero follows the normal 34-cycle path.

## Structure
- Package muldiv_pkg:
  - op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - state enum (MD_IDLE, MD_CALC, MD_FIX, MD_DONE);
  - constants MD_ITER=32 and MD_LATENCY=34.
- One sub-module, cla_adder32: a 32-bit adder with A, B, CARRY_I, SUM and CARRY_O, built from the team's 1-bit lookahead cells in 4-bit groups.
- muldiv_seq instantiates cla_adder32 exactly once and multiplexes its operands per state and op.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DONE pulses in cycle 34; BUSY high in cycles 1–34.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 -> LO=14, HI=2. This is followed by a back-to-back START in cycle 35, which must be accepted.
- MULTU 3×4 issued with prior HI/LO = 0x11/0x22 and CANCEL in cycle 10:
  - BUSY=0 in cycle 11;
  - no DONE;
  - HI/LO stay 0x11/0x22.
- DIVU 5/0:
  - DIV_ZERO_FLAG_EN off: DONE in cycle 34, LO=0xFFFFFFFF, HI=5.
  - DIV_ZERO_FLAG_EN on: DONE and DIV_ZERO in cycle 1, same HI/LO.
  - RST asserted in cycle 20 of another op: all outputs return to 0 immediately.
